// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive controller.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC_WAIT,
        SYNC_CHK,
        PID_WAIT,
        PID_CHK,
        DATA_WAIT,
        DATA_STORE,
        EOP_WAIT,
        DONE,
        ERR,
        ERR_IDLE
    } rx_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam int         PID_W     = 4;

    // PID codes as carried in the low nibble of the PID byte
    localparam logic [PID_W-1:0] PID_OUT   = 4'b0001;
    localparam logic [PID_W-1:0] PID_IN    = 4'b1001;
    localparam logic [PID_W-1:0] PID_DATA0 = 4'b0011;
    localparam logic [PID_W-1:0] PID_DATA1 = 4'b1011;
    localparam logic [PID_W-1:0] PID_ACK   = 4'b0010;
    localparam logic [PID_W-1:0] PID_NAK   = 4'b1010;

endpackage

// File: rtl/usb_rx_byte_tracker.sv
// Byte-boundary flag and saturating count of data bytes written for the current packet.
module usb_rx_byte_tracker #(
    parameter int MAX_BYTES = 66
) (
    input  logic clk,
    input  logic n_rst,
    input  logic byte_received,
    input  logic shift_enable,
    input  logic eop,
    input  logic inc,
    input  logic clear,
    output logic at_boundary,
    output logic at_max
);

    localparam int CNT_W = $clog2(MAX_BYTES + 1);

    logic [CNT_W-1:0] byte_cnt;

    // An EOP sample (shift with eop high) must not disturb the flag it is being judged against
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            at_boundary <= 1'b0;
        end else if (byte_received) begin
            at_boundary <= 1'b1;
        end else if (shift_enable && !eop) begin
            at_boundary <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (inc && !at_max) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign at_max = (byte_cnt == CNT_W'(MAX_BYTES));

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control FSM: SYNC/PID/data/EOP sequencing, FIFO writes, error flagging.
// Define USB_RX_PID_CHECK_EN to reject PID bytes whose check nibble is not the complement.
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int MAX_BYTES = 66
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    input  logic       buffer_full,
    output logic       cnt_clear,
    output logic       cnt_enable,
    output logic       rcving,
    output logic       w_enable,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic       packet_done,
    output logic       r_error
);

    rx_state_t state, next_state;
    logic      eop_seen;
    logic      pid_ok;
    logic      start_pkt;
    logic      at_boundary;
    logic      at_max;

`ifdef USB_RX_PID_CHECK_EN
    assign pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]);
`else
    assign pid_ok = 1'b1;
`endif

    assign start_pkt = d_edge && ((state == IDLE) || (state == ERR_IDLE));

    usb_rx_byte_tracker #(
        .MAX_BYTES(MAX_BYTES)
    ) u_byte_tracker (
        .clk          (clk),
        .n_rst        (n_rst),
        .byte_received(byte_received),
        .shift_enable (shift_enable),
        .eop          (eop),
        .inc          (w_enable),
        .clear        (cnt_clear),
        .at_boundary  (at_boundary),
        .at_max       (at_max)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_pid    <= 4'h0;
            pid_valid <= 1'b0;
        end else if (start_pkt) begin
            pid_valid <= 1'b0;
        end else if ((state == PID_CHK) && pid_ok) begin
            rx_pid    <= rcv_data[3:0];
            pid_valid <= 1'b1;
        end
    end

    // The error state only leaves on the J transition that ends an SE0 seen while in it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            eop_seen <= 1'b0;
        end else if (state != ERR) begin
            eop_seen <= 1'b0;
        end else if (eop) begin
            eop_seen <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        cnt_clear   = 1'b0;
        cnt_enable  = 1'b0;
        rcving      = 1'b0;
        w_enable    = 1'b0;
        packet_done = 1'b0;
        r_error     = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (d_edge) next_state = SYNC_WAIT;
            end
            SYNC_WAIT: begin
                rcving     = 1'b1;
                cnt_enable = shift_enable;
                if (byte_received)             next_state = SYNC_CHK;
                else if (eop && shift_enable)  next_state = ERR;
            end
            SYNC_CHK: begin
                rcving     = 1'b1;
                next_state = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
            end
            PID_WAIT: begin
                rcving     = 1'b1;
                cnt_enable = shift_enable;
                if (byte_received)             next_state = PID_CHK;
                else if (eop && shift_enable)  next_state = ERR;
            end
            PID_CHK: begin
                rcving     = 1'b1;
                next_state = pid_ok ? DATA_WAIT : ERR;
            end
            DATA_WAIT: begin
                rcving     = 1'b1;
                cnt_enable = shift_enable;
                if (byte_received)             next_state = DATA_STORE;
                else if (eop && shift_enable)  next_state = at_boundary ? EOP_WAIT : ERR;
            end
            DATA_STORE: begin
                rcving = 1'b1;
                if (buffer_full || at_max) begin
                    next_state = ERR;
                end else begin
                    w_enable   = 1'b1;
                    next_state = DATA_WAIT;
                end
            end
            EOP_WAIT: begin
                rcving = 1'b1;
                if (d_edge) next_state = DONE;
            end
            DONE: begin
                packet_done = 1'b1;
                next_state  = IDLE;
            end
            ERR: begin
                r_error = 1'b1;
                if (eop_seen && d_edge) next_state = ERR_IDLE;
            end
            ERR_IDLE: begin
                r_error   = 1'b1;
                cnt_clear = 1'b1;
                if (d_edge) next_state = SYNC_WAIT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/usb_rx_ctrl.md
# usb_rx_ctrl

Receive control unit for the USB full-speed receiver. Sequences each packet from the first line transition through SYNC, PID, data bytes and EOP. Gates the bit/byte counter, decides when a shifted byte is written to the RX FIFO, and flags framing, PID and overflow errors. Sits between the edge/EOP detectors plus shift register on one side and the RX FIFO plus protocol layer on the other.

## Interface
- MAX_BYTES, 66: maximum data bytes after PID (64 payload + CRC16); exceeding it is an error
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- d_edge  in  1  single-cycle pulse on a D+ transition
- eop  in  1  SE0 currently sampled
- shift_enable  in  1  single-cycle pulse at each bit sample point
- byte_received  in  1  single-cycle pulse when 8 bits have been shifted (counter rollover)
- rcv_data  in  8  last complete byte, LSB-first assembled
- buffer_full  in  1  RX FIFO full
- cnt_clear  out  1  synchronous clear to the bit counter
- cnt_enable  out  1  count strobe to the bit counter
- rcving  out  1  packet reception in progress
- w_enable  out  1  one-cycle FIFO write strobe for rcv_data
- rx_pid  out  4  PID of current/last packet
- pid_valid  out  1  rx_pid holds a checked PID for the current packet
- packet_done  out  1  one-cycle pulse on clean EOP
- r_error  out  1  sticky error for the current packet

## Operation
- States: IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, DATA_WAIT, DATA_STORE, EOP_WAIT, DONE, ERR, ERR_IDLE.
- IDLE: cnt_clear=1. d_edge goes to SYNC_WAIT, clears r_error and pid_valid, and sets rcving.
- SYNC_WAIT: byte_received goes to SYNC_CHK. SYNC_CHK: rcv_data==8'h80 goes to PID_WAIT, else ERR.
- PID_WAIT: byte_received goes to PID_CHK. PID_CHK: rcv_data[3:0]==~rcv_data[7:4] loads rx_pid=rcv_data[3:0], sets pid_valid and goes to DATA_WAIT; otherwise ERR.
- DATA_WAIT:
  - byte_received goes to DATA_STORE.
  - eop&&shift_enable at a byte boundary goes to EOP_WAIT.
  - eop&&shift_enable off a boundary goes to ERR.
- Byte boundary flag: set by byte_received; cleared by the first shift_enable with eop=0.
- DATA_STORE:
  - buffer_full=1 goes to ERR with no write.
  - byte count already MAX_BYTES goes to ERR with no write.
  - Otherwise w_enable=1, byte count +1, back to DATA_WAIT.
- EOP_WAIT: d_edge (return to J) goes to DONE. DONE: packet_done=1, rcving=0, go to IDLE.
- ERR: r_error=1, rcving=0. Waits until eop has been seen and then d_edge, then goes to ERR_IDLE.
- ERR_IDLE: cnt_clear=1. d_edge goes to SYNC_WAIT, clears r_error and sets rcving.
- eop&&shift_enable in SYNC_WAIT or PID_WAIT goes to ERR.
- cnt_enable = shift_enable in SYNC_WAIT, PID_WAIT and DATA_WAIT, else 0.
- Byte count width is $clog2(MAX_BYTES+1). The count saturates and never wraps. It clears in IDLE and ERR_IDLE.

## Timing
- Reset values:
  - state=IDLE, rcving=0, w_enable=0, cnt_enable=0, packet_done=0, r_error=0, pid_valid=0, rx_pid=4'h0, byte count=0.
  - cnt_clear=1 during reset, because it is decoded from state IDLE.
- Outputs are Moore-decoded from registered state, except cnt_enable, which is a combinational AND with shift_enable.
- byte_received at edge k: CHK/STORE state occupies cycle k+1; w_enable is high exactly in cycle k+1; the next state is effective at k+2.
- d_edge and byte_received in the same cycle in IDLE: only d_edge acts.
- eop and byte_received in the same cycle in DATA_WAIT: byte_received wins; eop is evaluated on the next shift_enable.
- n_rst asserted mid-packet aborts immediately. No partial w_enable, no packet_done.

## Configuration
- USB_RX_PID_CHECK_EN defined: PID_CHK performs the complement check as above.
- Undefined: PID_CHK always loads rx_pid, sets pid_valid and goes to DATA_WAIT; a bad PID never raises r_error.

## Structure
- usb_rx_pkg holds:
  - the rx_state_t enum
  - SYNC_BYTE=8'h80
  - the PID_W=4 constant
  - PID code localparams (OUT, IN, DATA0, DATA1, ACK, NAK) for consumers
- One sub-module, usb_rx_byte_tracker, holds the boundary flag and the saturating byte counter with inc/clear/at_max.

## Test plan
- Sync 0x80, PID 0xC3 (DATA0), 3 data bytes, clean EOP: 3 w_enable pulses one cycle after each byte_received; rx_pid=4'h3, pid_valid=1; packet_done one pulse; r_error=0.
- Sync 0x81: ERR one cycle after byte_received, r_error=1 and rcving=0. It stays set through EOP and clears on the next d_edge.
- PID byte 0xC2, macro defined: r_error=1, pid_valid=0, no w_enable. Macro undefined: rx_pid=4'h2, no error.
- EOP after 3 bits of a data byte: r_error=1, no packet_done, no write of the partial byte.
- buffer_full=1 on the 2nd data byte: first byte written, r_error=1, exactly one w_enable.
- MAX_BYTES=2 with 3 data bytes sent: 2 writes, then r_error=1. n_rst mid-PID returns all outputs to reset values.
